// File: rtl/i281_pkg.sv
// rtl/i281_pkg.sv - shared i281 opcodes, instruction field positions and sequencer state type
package i281_pkg;

  localparam logic [3:0] OPC_NOOP   = 4'h0;
  localparam logic [3:0] OPC_INPUTC = 4'h1;
  localparam logic [3:0] OPC_MOVE   = 4'h2;
  localparam logic [3:0] OPC_LOADI  = 4'h3;
  localparam logic [3:0] OPC_ADD    = 4'h4;
  localparam logic [3:0] OPC_ADDI   = 4'h5;
  localparam logic [3:0] OPC_SUB    = 4'h6;
  localparam logic [3:0] OPC_SUBI   = 4'h7;
  localparam logic [3:0] OPC_LOAD   = 4'h8;
  localparam logic [3:0] OPC_LOADF  = 4'h9;
  localparam logic [3:0] OPC_STORE  = 4'hA;
  localparam logic [3:0] OPC_STOREF = 4'hB;
  localparam logic [3:0] OPC_SHIFT  = 4'hC;
  localparam logic [3:0] OPC_CMP    = 4'hD;
  localparam logic [3:0] OPC_JUMP   = 4'hE;
  localparam logic [3:0] OPC_BRANCH = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int X_MSB   = 11;
  localparam int X_LSB   = 10;
  localparam int Y_MSB   = 9;
  localparam int Y_LSB   = 8;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} seq_state_t;

  function automatic logic writes_reg(input logic [3:0] opc);
    case (opc)
      OPC_MOVE, OPC_LOADI, OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI,
      OPC_LOAD, OPC_LOADF, OPC_SHIFT: writes_reg = 1'b1;
      default:                        writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i281_regfile_sequencer_classify.sv
// rtl/i281_regfile_sequencer_classify.sv - combinational opcode classifier (i281_opc_classify)
module i281_opc_classify
  import i281_pkg::*;
(
  input  logic [3:0] opc,
  output logic       writes,
  output logic       is_load,
  output logic       uses_y
);

  always_comb begin
    writes  = writes_reg(opc);
    is_load = (opc == OPC_LOAD) || (opc == OPC_LOADF);
    uses_y  = !((opc == OPC_SHIFT) || (opc == OPC_LOADI));
  end

endmodule

// File: rtl/i281_regfile_sequencer.sv
// rtl/i281_regfile_sequencer.sv - DECODE/EXEC/WRITE sequencer driving register file selects c4..c10
// Optional retire counter port enabled by defining I281_SEQ_RETIRE_CNT_EN.
module i281_regfile_sequencer
  import i281_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               c4,
  output logic               c5,
  output logic               c6,
  output logic               c7,
  output logic               c8,
  output logic               c9,
  output logic               c10,
  output logic               mem_rd,
  output logic               busy
`ifdef I281_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);

  localparam logic [3:0] LOAD_CNT = 4'(MEM_LAT - 1);

  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               cls_writes, cls_is_load, cls_uses_y;
  logic [1:0]         x_f, y_f;
  logic               unused_imm;

  assign x_f        = ir_q[X_MSB:X_LSB];
  assign y_f        = ir_q[Y_MSB:Y_LSB];
  assign unused_imm = ^ir_q[Y_LSB-1:0];

  i281_opc_classify u_classify (
    .opc     (ir_q[OPC_MSB:OPC_LSB]),
    .writes  (cls_writes),
    .is_load (cls_is_load),
    .uses_y  (cls_uses_y)
  );

  // Everything freezes while run is low, so a resume picks up mid-instruction.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    if (run) begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            ir_d    = instr;
            state_d = DECODE;
          end
        end
        DECODE: begin
          state_d = EXEC;
          cnt_d   = cls_is_load ? LOAD_CNT : 4'd0;
        end
        EXEC: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = cls_writes ? WRITE : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    instr_ready = (state_q == IDLE) && run;
    busy        = (state_q != IDLE);
    {c4, c5}    = busy ? x_f : 2'b00;
    {c6, c7}    = (busy && cls_uses_y) ? y_f : 2'b00;
    {c8, c9}    = (state_q == WRITE) ? x_f : 2'b00;
    c10         = (state_q == WRITE) && run;
    mem_rd      = (state_q == EXEC) && cls_is_load && run;
  end

`ifdef I281_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (state_q != IDLE && state_d == IDLE) retire_cnt_d = retire_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) retire_cnt_q <= '0;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
